// File: rtl/tx_burst_ctrl_if.sv
// Bus bundle for tx_burst_ctrl: control inputs, upstream I/Q samples,
// and the gated sample pair / status outputs toward the downstream gate.
interface tx_burst_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              en;
  logic              start;
  logic [CNT_W-1:0]  on_len;
  logic [CNT_W-1:0]  off_len;
  logic [7:0]        burst_num;
  logic              sample_en;
  logic [DATA_W-1:0] in_i;
  logic [DATA_W-1:0] in_q;
  logic [DATA_W-1:0] out_i;
  logic [DATA_W-1:0] out_q;
  logic              mode;
  logic              busy;
  logic              done;

  // Driver side (controller / testbench)
  modport master (
    output en, start, on_len, off_len, burst_num, sample_en, in_i, in_q,
    input  out_i, out_q, mode, busy, done
  );

  // Burst controller side
  modport slave (
    input  en, start, on_len, off_len, burst_num, sample_en, in_i, in_q,
    output out_i, out_q, mode, busy, done
  );
endinterface

// File: rtl/tx_burst_ctrl.sv
// TX burst controller: after a start request, spends GUARD_LEN sample
// strobes in GUARD, then alternates ON (on_len strobes) and OFF (off_len
// strobes) for burst_num bursts (0 = forever). mode gates the registered
// I/Q pair and is aligned with the sample it qualifies.
module tx_burst_ctrl #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16,
  parameter int GUARD_LEN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  tx_burst_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } state_t;

  // Last counter value of the guard interval (unused when GUARD_LEN is 0)
  localparam logic [CNT_W-1:0] GUARD_LAST =
    CNT_W'((GUARD_LEN > 0) ? (GUARD_LEN - 1) : 0);
  localparam bit GUARD_SKIP = (GUARD_LEN == 0);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_on_len;
  logic [CNT_W-1:0]  r_off_len;
  logic [7:0]        r_burst;
  logic [7:0]        r_burst_num;
  logic [DATA_W-1:0] r_out_i;
  logic [DATA_W-1:0] r_out_q;
  logic              r_mode;
  logic              r_busy;
  logic              r_done;

  logic [CNT_W-1:0]  w_cnt_inc;
  logic [7:0]        w_burst_inc;
  logic              w_accept;
  logic              w_guard_hit;
  logic              w_on_hit;
  logic              w_off_hit;
  logic              w_last_burst;
  logic              w_load;
  logic              w_reenter;
  logic              w_seq_done;
  logic              w_on_exit;
  logic              w_entry;

  assign w_cnt_inc    = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_burst_inc  = r_burst + 8'd1;
  assign w_accept     = bus.en && bus.start && (bus.on_len != {CNT_W{1'b0}});
  // A phase ends on the strobe that completes its length; that strobe
  // belongs to the ending phase, so the next phase starts counting at 0.
  assign w_guard_hit  = GUARD_SKIP ? 1'b1 : (bus.sample_en && (r_cnt == GUARD_LAST));
  assign w_on_hit     = bus.sample_en && (w_cnt_inc == r_on_len);
  assign w_off_hit    = bus.sample_en && (w_cnt_inc == r_off_len);
  assign w_last_burst = (r_burst_num != 8'd0) && (w_burst_inc == r_burst_num);

  // Next-state and transition qualifiers; en low overrides everything
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_reenter  = 1'b0;
    w_seq_done = 1'b0;
    w_on_exit  = 1'b0;
    if (!bus.en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_next = ST_GUARD;
            w_load = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_GUARD: begin
          if (w_guard_hit) begin
            w_next = ST_ON;
          end else begin
            w_next = ST_GUARD;
          end
        end
        ST_ON: begin
          if (w_on_hit) begin
            w_on_exit = 1'b1;
            if (w_last_burst) begin
              w_next     = ST_IDLE;
              w_seq_done = 1'b1;
            end else if (r_off_len == {CNT_W{1'b0}}) begin
              w_next    = ST_ON;
              w_reenter = 1'b1;
            end else begin
              w_next = ST_OFF;
            end
          end else begin
            w_next = ST_ON;
          end
        end
        ST_OFF: begin
          if (w_off_hit) begin
            w_next = ST_ON;
          end else begin
            w_next = ST_OFF;
          end
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  assign w_entry = (w_next != r_state) || w_reenter;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Phase length counter: cleared on every state entry and while idle,
  // otherwise advances only on sample strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_entry || (w_next == ST_IDLE)) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (bus.sample_en) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Burst counter: restarts with each sequence, wraps freely in continuous mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= 8'd0;
    end else if (w_load) begin
      r_burst <= 8'd0;
    end else if (w_on_exit) begin
      r_burst <= w_burst_inc;
    end else begin
      r_burst <= r_burst;
    end
  end

  // Sequence parameters captured at acceptance so mid-sequence input changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_on_len    <= {CNT_W{1'b0}};
      r_off_len   <= {CNT_W{1'b0}};
      r_burst_num <= 8'd0;
    end else if (w_load) begin
      r_on_len    <= bus.on_len;
      r_off_len   <= bus.off_len;
      r_burst_num <= bus.burst_num;
    end else begin
      r_on_len    <= r_on_len;
      r_off_len   <= r_off_len;
      r_burst_num <= r_burst_num;
    end
  end

  // Sample pipeline: one cycle of latency regardless of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_i <= {DATA_W{1'b0}};
      r_out_q <= {DATA_W{1'b0}};
    end else begin
      r_out_i <= bus.in_i;
      r_out_q <= bus.in_q;
    end
  end

  // Status outputs registered from next state so mode lines up with the sample it gates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_mode <= (w_next == ST_ON);
      r_busy <= (w_next != ST_IDLE);
      r_done <= w_seq_done;
    end
  end

  assign bus.out_i = r_out_i;
  assign bus.out_q = r_out_q;
  assign bus.mode  = r_mode;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_tx_burst_ctrl.sv
// Self-checking bench for tx_burst_ctrl: a strobe-count model of the burst
// timeline is compared against the DUT every cycle, plus directed scenarios
// with hand-computed expectations.
module tb_tx_burst_ctrl;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int G  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  tx_burst_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  tx_burst_ctrl #(.DATA_W(DW), .CNT_W(CW), .GUARD_LEN(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence is described by k = sample strobes seen since
  // acceptance. k < G is guard; beyond it, position p = k-G within a
  // period of on+off strobes decides on/off; a finite sequence ends once
  // p reaches the end of the last burst's on-time.
  typedef struct {
    bit act;
    int k;
    int on;
    int off;
    int n;
    bit done;
    bit mode;
  } mdl_t;

  function automatic mdl_t mstep(input mdl_t c, input logic en, input logic start,
                                 input int onl, input int offl, input int num,
                                 input logic se);
    mdl_t r;
    int   p;
    r      = c;
    r.done = 1'b0;
    if (!en) begin
      r.act = 1'b0;
    end else if (!r.act) begin
      if (start && onl != 0) begin
        r.act = 1'b1;
        r.k   = 0;
        r.on  = onl;
        r.off = offl;
        r.n   = num;
      end
    end else begin
      if (se) r.k = r.k + 1;
      if (r.k >= G && r.n != 0) begin
        p = r.k - G;
        if (p >= (r.n - 1) * (r.on + r.off) + r.on) begin
          r.act  = 1'b0;
          r.done = 1'b1;
        end
      end
    end
    r.mode = 1'b0;
    if (r.act && r.k >= G) begin
      r.mode = (((r.k - G) % (r.on + r.off)) < r.on);
    end
    return r;
  endfunction

  mdl_t          m;
  logic [DW-1:0] e_i;
  logic [DW-1:0] e_q;

  // Model state advances with the DUT clock and clears on async reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m   <= '{act: 1'b0, k: 0, on: 0, off: 0, n: 0, done: 1'b0, mode: 1'b0};
      e_i <= '0;
      e_q <= '0;
    end else begin
      m   <= mstep(m, bus.en, bus.start, int'(bus.on_len), int'(bus.off_len),
                   int'(bus.burst_num), bus.sample_en);
      e_i <= bus.in_i;
      e_q <= bus.in_q;
    end
  end

  // Every-cycle comparison on the opposite edge
  always @(negedge clk) begin
    check("mode",  {31'd0, bus.mode}, {31'd0, m.mode});
    check("busy",  {31'd0, bus.busy}, {31'd0, m.act});
    check("done",  {31'd0, bus.done}, {31'd0, m.done});
    check("out_i", {16'd0, bus.out_i}, {16'd0, e_i});
    check("out_q", {16'd0, bus.out_q}, {16'd0, e_q});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go_idle();
    bus.start = 1'b0;
    bus.en    = 1'b0;
    tick();
    bus.en    = 1'b1;
    tick();
  endtask

  task automatic wait_mode();
    int i;
    i = 0;
    while (bus.mode !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    if (i >= 200) check("wait_mode_timeout", 32'd0, 32'd1);
  endtask

  task automatic launch(input int onl, input int offl, input int num);
    bus.on_len    = CW'(onl);
    bus.off_len   = CW'(offl);
    bus.burst_num = 8'(num);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  logic [12:0] pat;
  int          cnt_hi, cnt_rise, cnt_done;
  logic        prev_mode;

  initial begin
    bus.en = 1'b0; bus.start = 1'b0; bus.on_len = '0; bus.off_len = '0;
    bus.burst_num = '0; bus.sample_en = 1'b0; bus.in_i = '0; bus.in_q = '0;
    #1 rst_n = 1'b0;
    tick();
    check("rst_mode", {31'd0, bus.mode}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_out_i", {16'd0, bus.out_i}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.sample_en = 1'b1;
    tick();

    // Basic sequence: 4 guard, 3 on, 2 off, 3 on, then done
    pat = 13'b0111001110000;
    launch(3, 2, 2);
    for (int j = 0; j < 13; j++) begin
      check("seq_mode", {31'd0, bus.mode}, {31'd0, pat[j]});
      check("seq_busy", {31'd0, bus.busy}, (j < 12) ? 32'd1 : 32'd0);
      check("seq_done", {31'd0, bus.done}, (j == 12) ? 32'd1 : 32'd0);
      if (j < 12) tick();
    end
    tick();

    // Sample data latency
    bus.in_i = 16'h1234;
    bus.in_q = 16'hABCD;
    tick();
    bus.in_i = 16'h0000;
    bus.in_q = 16'h0000;
    check("lat_out_i", {16'd0, bus.out_i}, 32'h1234);
    check("lat_out_q", {16'd0, bus.out_q}, 32'hABCD);
    tick();
    check("lat_out_i_next", {16'd0, bus.out_i}, 32'h0000);

    // Strobe every 4th cycle: on_len=2 gives 8 clk cycles of mode per burst
    go_idle();
    cnt_hi = 0; cnt_done = 0;
    bus.sample_en = 1'b0;
    launch(2, 3, 1);
    for (int c = 0; c < 100; c++) begin
      bus.sample_en = (c % 4 == 3);
      if (bus.mode) cnt_hi++;
      if (bus.done) cnt_done++;
      tick();
    end
    check("sparse_on_cycles", cnt_hi, 32'd8);
    check("sparse_done_cnt", cnt_done, 32'd1);
    bus.sample_en = 1'b1;

    // off_len=0: three bursts back to back
    go_idle();
    cnt_hi = 0; cnt_rise = 0; cnt_done = 0; prev_mode = 1'b0;
    launch(2, 0, 3);
    for (int c = 0; c < 40; c++) begin
      if (bus.mode) cnt_hi++;
      if (bus.mode && !prev_mode) cnt_rise++;
      if (bus.done) cnt_done++;
      prev_mode = bus.mode;
      tick();
    end
    check("cont_on_cycles", cnt_hi, 32'd6);
    check("cont_rises", cnt_rise, 32'd1);
    check("cont_done_cnt", cnt_done, 32'd1);

    // Continuous mode across burst counter wrap
    go_idle();
    launch(1, 0, 0);
    for (int c = 0; c < 600; c++) tick();
    check("wrap_mode", {31'd0, bus.mode}, 32'd1);
    check("wrap_busy", {31'd0, bus.busy}, 32'd1);

    // en dropped mid-ON, together with a start request
    go_idle();
    launch(5, 2, 0);
    wait_mode();
    bus.en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("en_drop_mode", {31'd0, bus.mode}, 32'd0);
    check("en_drop_busy", {31'd0, bus.busy}, 32'd0);
    cnt_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) cnt_done++;
      tick();
    end
    check("en_drop_no_done", cnt_done, 32'd0);

    // Asynchronous reset mid-ON
    go_idle();
    bus.in_i = 16'h5A5A;
    launch(3, 1, 0);
    wait_mode();
    #1 rst_n = 1'b0;
    #1;
    check("arst_mode", {31'd0, bus.mode}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_out_i", {16'd0, bus.out_i}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, bus.busy}, 32'd0);
    bus.in_i = 16'h0000;
    launch(0, 1, 1);
    check("zero_len_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("zero_len_busy2", {31'd0, bus.busy}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bus.en        = ($urandom_range(63) != 0);
      bus.start     = ($urandom_range(15) == 0);
      bus.on_len    = CW'($urandom_range(5));
      bus.off_len   = CW'($urandom_range(4));
      bus.burst_num = 8'($urandom_range(4));
      bus.sample_en = ($urandom_range(2) != 0);
      bus.in_i      = DW'($urandom);
      bus.in_q      = DW'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
